mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_PAIRS, 16, number of operand pairs processed per run.
REQ-002 SHALL have parameter SRC_BASE, 0, data-memory byte address of the first operand.
REQ-003 SHALL have parameter DST_BASE, 64, data-memory byte address of the first product.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start  input  1  run request, sampled only in IDLE or DONE.
REQ-007 SHALL have port done  output  1  high when a run has completed; held until the next run or reset.
REQ-008 SHALL have port busy  output  1  high in LOAD, MULT and STORE.
REQ-009 SHALL have port mem_addr  output  8  byte address to data memory.
REQ-010 SHALL have port mem_rd_data  input  8  combinational read data for mem_addr.
REQ-011 SHALL have port mem_wr_en  output  1  write strobe; memory writes on the rising edge while high.
REQ-012 SHALL have port mem_wr_data  output  8  write data.

Function
REQ-013 SHALL implement the states IDLE, LOAD, MULT, STORE and DONE.
REQ-014 SHALL transition IDLE->LOAD, or DONE->LOAD, on an edge sampling start=1, with pair index k=0.
REQ-015 SHALL spend exactly 4 edges in LOAD for pair k, driving mem_addr=SRC_BASE+4k+i for i=0..3.
REQ-016 SHALL capture the LOAD bytes so that A={byte0,byte1} and B={byte2,byte3}, both 16-bit two's complement, big-endian.
REQ-017 SHALL spend exactly 16 edges in MULT, using an iterative one-bit-per-cycle signed multiply (radix-2 Booth or equivalent) that produces the exact 32-bit product P=B*A, with no saturation.
REQ-018 SHALL NOT contain a combinational 16x16 multiplier.
REQ-019 SHALL spend exactly 4 edges in STORE with mem_wr_en=1, mem_addr=DST_BASE+4k+i, and mem_wr_data=P[31-8i:24-8i] for i=0..3 (big-endian).
REQ-020 SHALL, after the 4th STORE edge, go to LOAD with k+1 if k<NUM_PAIRS-1, else to DONE.
REQ-021 Per-pair latency SHALL be 24 edges; done SHALL rise on edge 24*NUM_PAIRS after the start-sampling edge (384 for the defaults).
REQ-022 SHALL keep mem_wr_en=0 in every state except STORE.
REQ-023 SHALL drive mem_addr=0 and mem_wr_data=0 in IDLE and DONE.
REQ-024 SHALL ignore start while busy=1, with no restart and no effect on the pair index or the product.
REQ-025 SHALL, on start sampled in DONE, drop done on that same edge and begin a new run from k=0.
REQ-026 SHALL handle the corner cases exactly: -32768*-32768=0x40000000; 32767*-32768=0xC0008000; 0*x=0.
REQ-027 Parameter legality SHALL be SRC_BASE+4*NUM_PAIRS-1<=255 and DST_BASE+4*NUM_PAIRS-1<=255, with no address wrap-around; SRC and DST overlap is out of scope.

Reset
REQ-028 SHALL, while reset=0, force immediately (asynchronously): state=IDLE, k=0, done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and clear the product and operand registers.
REQ-029 SHALL treat reset asserted mid-run as an abort: memory bytes already written stay written, and no further writes occur.
REQ-030 SHALL require the first start after reset deassertion to run a complete fresh sequence from k=0.

Verification
REQ-031 Single pair, NUM_PAIRS=1: mem[0..3]=00 03 FF FB (A=3, B=-5), pulse start -> mem[64..67]=FF FF FF F1 and done high 24 edges after the start edge.
REQ-032 Corner products: pair0 -32768*-32768 and pair1 32767*-32768 -> mem[64..67]=40 00 00 00 and mem[68..71]=C0 00 80 00; a zero operand gives 00 00 00 00.
REQ-033 Full run: 16 random pairs in mem[0..63], start -> every mem[64+4k..67+4k] equals the signed product, done rises on edge 384, and mem_wr_en is never high outside mem[64..127].
REQ-034 Start re-pulsed at edges 10 and 200 of a run -> no effect; done is still at edge 384 and the results are unchanged.
REQ-035 Reset=0 asserted at edge 100 -> done=0, busy=0 and mem_wr_en=0 with no clock edge needed; release, then start -> a correct full run with done at edge 384.
REQ-036 After done, change the operands and pulse start -> done drops on the start edge, then the new products appear and done rises again 384 edges later.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequential signed 16x16 multiplier controller: reads operand pairs from a byte memory,
// multiplies them with a radix-2 Booth datapath and writes the 32-bit products back.
module mult_seq_ctrl #(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MULT,
        STORE,
        DONE
    } state_t;

    localparam logic [7:0] SRC  = 8'(SRC_BASE);
    localparam logic [7:0] DST  = 8'(DST_BASE);
    localparam logic [5:0] LAST = 6'(NUM_PAIRS - 1);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [5:0]  k;
    logic [15:0] a_reg, b_reg;
    logic [16:0] acc;
    logic [15:0] lo;
    logic        q1;
    logic [16:0] m_ext, sum;
    logic [31:0] product;
    logic [7:0]  pair_off;

    assign product  = {acc[15:0], lo};
    assign pair_off = {k, 2'b00};

    // One Booth step; the 17-bit accumulator absorbs the -32768 operand without overflow.
    always_comb begin
        m_ext = {b_reg[15], b_reg};
        sum   = acc;
        case ({lo[0], q1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 8'h00;
        mem_wr_data = 8'h00;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                mem_addr = SRC + pair_off + {6'b0, cnt[1:0]};
                if (cnt == 4'd3) state_next = MULT;
            end
            MULT: begin
                busy = 1'b1;
                if (cnt == 4'd15) state_next = STORE;
            end
            STORE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = DST + pair_off + {6'b0, cnt[1:0]};
                case (cnt[1:0])
                    2'd0:    mem_wr_data = product[31:24];
                    2'd1:    mem_wr_data = product[23:16];
                    2'd2:    mem_wr_data = product[15:8];
                    default: mem_wr_data = product[7:0];
                endcase
                if (cnt == 4'd3) state_next = (k == LAST) ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Step counter restarts on every state change; pair index advances only after a store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            k     <= 6'd0;
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
            acc   <= 17'h00000;
            lo    <= 16'h0000;
            q1    <= 1'b0;
        end else begin
            if (state_next != state) cnt <= 4'd0;
            else if (busy)           cnt <= cnt + 4'd1;
            else                     cnt <= 4'd0;

            if ((state == IDLE || state == DONE) && start)
                k <= 6'd0;
            else if (state == STORE && cnt == 4'd3 && k != LAST)
                k <= k + 6'd1;

            if (state == LOAD) begin
                case (cnt[1:0])
                    2'd0: a_reg[15:8] <= mem_rd_data;
                    2'd1: a_reg[7:0]  <= mem_rd_data;
                    2'd2: b_reg[15:8] <= mem_rd_data;
                    default: begin
                        b_reg[7:0] <= mem_rd_data;
                        acc        <= 17'h00000;
                        lo         <= a_reg;
                        q1         <= 1'b0;
                    end
                endcase
            end else if (state == MULT) begin
                acc <= {sum[16], sum[16:1]};
                lo  <= {sum[0], lo[15:1]};
                q1  <= lo[0];
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: a 16-pair instance for full runs and a 1-pair instance.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic       done_a, busy_a, we_a, done_b, busy_b, we_b;
    logic [7:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       tb_we_a, tb_we_b;
    logic [7:0] tb_addr, tb_data;

    logic [15:0] op_a [16];
    logic [15:0] op_b [16];
    logic [31:0] exp_p [16];

    int checks = 0;
    int failures = 0;
    int viol_a = 0;
    int viol_b = 0;

    mult_seq_ctrl dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .done(done_a), .busy(busy_a),
        .mem_addr(addr_a), .mem_rd_data(rd_a), .mem_wr_en(we_a), .mem_wr_data(wd_a)
    );

    mult_seq_ctrl #(.NUM_PAIRS(1), .SRC_BASE(0), .DST_BASE(64)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .done(done_b), .busy(busy_b),
        .mem_addr(addr_b), .mem_rd_data(rd_b), .mem_wr_en(we_b), .mem_wr_data(wd_b)
    );

    assign rd_a = mem_a[addr_a];
    assign rd_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_a)    mem_a[addr_a] <= wd_a;
        if (tb_we_a) mem_a[tb_addr] <= tb_data;
        if (we_b)    mem_b[addr_b] <= wd_b;
        if (tb_we_b) mem_b[tb_addr] <= tb_data;
    end

    always @(posedge clk) begin
        if (we_a && (addr_a < 8'd64 || addr_a > 8'd127)) viol_a++;
        if (we_b && (addr_b < 8'd64 || addr_b > 8'd67))  viol_b++;
    end

    task automatic poke(input bit sel, input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        tb_addr = addr;
        tb_data = data;
        tb_we_a = !sel;
        tb_we_b = sel;
        @(negedge clk);
        tb_we_a = 1'b0;
        tb_we_b = 1'b0;
    endtask

    task automatic load_pairs();
        int ia, ib;
        for (int k = 0; k < 16; k++) begin
            poke(1'b0, 8'(4 * k),     op_a[k][15:8]);
            poke(1'b0, 8'(4 * k + 1), op_a[k][7:0]);
            poke(1'b0, 8'(4 * k + 2), op_b[k][15:8]);
            poke(1'b0, 8'(4 * k + 3), op_b[k][7:0]);
            ia = $signed(op_a[k]);
            ib = $signed(op_b[k]);
            exp_p[k] = ia * ib;
        end
    endtask

    task automatic fill_dst_a(input logic [7:0] val);
        for (int i = 64; i < 128; i++) poke(1'b0, 8'(i), val);
    endtask

    // Start on the next edge (edge 0) and count edges until done, optionally re-pulsing start.
    task automatic run(input bit sel, input bit repulse, output int done_edge,
                       output logic done_after0, output logic busy_at1);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        done_after0 = sel ? done_b : done_a;
        busy_at1 = 1'b0;
        done_edge = -1;
        for (int n = 1; n <= 500; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) busy_at1 = sel ? busy_b : busy_a;
            start_a = repulse && (n == 9 || n == 199);
            if ((sel ? done_b : done_a) === 1'b1) begin
                done_edge = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks += 7;
        if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b expected=0", done_a); end
        if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b expected=0", busy_a); end
        if (we_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b expected=0", we_a); end
        if (addr_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_addr got=%h expected=00", addr_a); end
        if (wd_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_wr_data got=%h expected=00", wd_a); end
        if (done_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_done_b got=%b expected=0", done_b); end
        if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_b got=%b expected=0", busy_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pair();
        int de;
        logic d0, b1;
        logic [31:0] got;
        poke(1'b1, 8'd0, 8'h00);
        poke(1'b1, 8'd1, 8'h03);
        poke(1'b1, 8'd2, 8'hFF);
        poke(1'b1, 8'd3, 8'hFB);
        for (int i = 64; i < 68; i++) poke(1'b1, 8'(i), 8'hAA);
        run(1'b1, 1'b0, de, d0, b1);
        got = {mem_b[64], mem_b[65], mem_b[66], mem_b[67]};
        checks += 6;
        if (d0 !== 1'b0) begin failures++; $display("[TB] FAIL single_done_edge0 got=%b expected=0", d0); end
        if (b1 !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b expected=1", b1); end
        if (de != 24) begin failures++; $display("[TB] FAIL single_latency got=%0d expected=24", de); end
        if (got !== 32'hFFFFFFF1) begin failures++; $display("[TB] FAIL single_product got=%h expected=fffffff1", got); end
        if (addr_b !== 8'h00 || wd_b !== 8'h00) begin
            failures++; $display("[TB] FAIL single_done_outputs got=%h/%h expected=00/00", addr_b, wd_b);
        end
        if (we_b !== 1'b0) begin failures++; $display("[TB] FAIL single_done_wr_en got=%b expected=0", we_b); end
    endtask

    task automatic test_full_run();
        int de;
        logic d0, b1;
        logic [31:0] got;
        op_a[0]  = 16'h8000; op_b[0]  = 16'h8000;
        op_a[1]  = 16'h7FFF; op_b[1]  = 16'h8000;
        op_a[2]  = 16'h0000; op_b[2]  = 16'h1234;
        op_a[3]  = 16'h0003; op_b[3]  = 16'hFFFB;
        op_a[4]  = 16'hFFFF; op_b[4]  = 16'hFFFF;
        op_a[5]  = 16'h0064; op_b[5]  = 16'h00C8;
        op_a[6]  = 16'hFF9C; op_b[6]  = 16'h00C8;
        op_a[7]  = 16'h7FFF; op_b[7]  = 16'h7FFF;
        op_a[8]  = 16'h8000; op_b[8]  = 16'h0001;
        op_a[9]  = 16'h1234; op_b[9]  = 16'h5678;
        op_a[10] = 16'hA5A5; op_b[10] = 16'h3C3C;
        op_a[11] = 16'h0F0F; op_b[11] = 16'hF0F0;
        op_a[12] = 16'h0001; op_b[12] = 16'h0001;
        op_a[13] = 16'h8001; op_b[13] = 16'h7FFF;
        op_a[14] = 16'hABCD; op_b[14] = 16'h0000;
        op_a[15] = 16'h0100; op_b[15] = 16'h0100;
        load_pairs();
        fill_dst_a(8'hEE);
        run(1'b0, 1'b0, de, d0, b1);
        checks += 8;
        if (de != 384) begin failures++; $display("[TB] FAIL full_latency got=%0d expected=384", de); end
        if (b1 !== 1'b1) begin failures++; $display("[TB] FAIL full_busy got=%b expected=1", b1); end
        got = {mem_a[64], mem_a[65], mem_a[66], mem_a[67]};
        if (got !== 32'h40000000) begin failures++; $display("[TB] FAIL corner_min_min got=%h expected=40000000", got); end
        got = {mem_a[68], mem_a[69], mem_a[70], mem_a[71]};
        if (got !== 32'hC0008000) begin failures++; $display("[TB] FAIL corner_max_min got=%h expected=c0008000", got); end
        got = {mem_a[72], mem_a[73], mem_a[74], mem_a[75]};
        if (got !== 32'h00000000) begin failures++; $display("[TB] FAIL corner_zero got=%h expected=00000000", got); end
        got = {mem_a[80], mem_a[81], mem_a[82], mem_a[83]};
        if (got !== 32'h00000001) begin failures++; $display("[TB] FAIL neg1_neg1 got=%h expected=00000001", got); end
        got = {mem_a[88], mem_a[89], mem_a[90], mem_a[91]};
        if (got !== 32'hFFFFB1E0) begin failures++; $display("[TB] FAIL neg100_200 got=%h expected=ffffb1e0", got); end
        got = {mem_a[92], mem_a[93], mem_a[94], mem_a[95]};
        if (got !== 32'h3FFF0001) begin failures++; $display("[TB] FAIL max_max got=%h expected=3fff0001", got); end
        for (int k = 0; k < 16; k++) begin
            got = {mem_a[64 + 4 * k], mem_a[65 + 4 * k], mem_a[66 + 4 * k], mem_a[67 + 4 * k]};
            checks++;
            if (got !== exp_p[k]) begin
                failures++; $display("[TB] FAIL full_pair%0d got=%h expected=%h", k, got, exp_p[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int de;
        logic d0, b1;
        logic [31:0] got;
        fill_dst_a(8'hEE);
        run(1'b0, 1'b1, de, d0, b1);
        checks += 2;
        if (d0 !== 1'b0) begin failures++; $display("[TB] FAIL repulse_done_drop got=%b expected=0", d0); end
        if (de != 384) begin failures++; $display("[TB] FAIL repulse_latency got=%0d expected=384", de); end
        for (int k = 0; k < 16; k++) begin
            got = {mem_a[64 + 4 * k], mem_a[65 + 4 * k], mem_a[66 + 4 * k], mem_a[67 + 4 * k]};
            checks++;
            if (got !== exp_p[k]) begin
                failures++; $display("[TB] FAIL repulse_pair%0d got=%h expected=%h", k, got, exp_p[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int de;
        logic d0, b1;
        logic [31:0] got;
        fill_dst_a(8'hEE);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got=%b expected=0", done_a); end
        if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b expected=0", busy_a); end
        if (we_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_wr_en got=%b expected=0", we_a); end
        if (addr_a !== 8'h00) begin failures++; $display("[TB] FAIL abort_addr got=%h expected=00", addr_a); end
        repeat (3) @(posedge clk);
        #1;
        got = {mem_a[76], mem_a[77], mem_a[78], mem_a[79]};
        checks += 2;
        if (got !== exp_p[3]) begin failures++; $display("[TB] FAIL abort_kept got=%h expected=%h", got, exp_p[3]); end
        got = {mem_a[80], mem_a[81], mem_a[82], mem_a[83]};
        if (got !== 32'hEEEEEEEE) begin failures++; $display("[TB] FAIL abort_no_write got=%h expected=eeeeeeee", got); end
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 1'b0, de, d0, b1);
        checks += 1;
        if (de != 384) begin failures++; $display("[TB] FAIL abort_rerun_latency got=%0d expected=384", de); end
        for (int k = 0; k < 16; k++) begin
            got = {mem_a[64 + 4 * k], mem_a[65 + 4 * k], mem_a[66 + 4 * k], mem_a[67 + 4 * k]};
            checks++;
            if (got !== exp_p[k]) begin
                failures++; $display("[TB] FAIL abort_rerun_pair%0d got=%h expected=%h", k, got, exp_p[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int de;
        logic d0, b1;
        logic [31:0] got;
        for (int k = 0; k < 16; k++) begin
            op_a[k] = 16'(k * 977 - 3000);
            op_b[k] = 16'(12345 - k * 2049);
        end
        load_pairs();
        run(1'b0, 1'b0, de, d0, b1);
        checks += 2;
        if (d0 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_drop got=%b expected=0", d0); end
        if (de != 384) begin failures++; $display("[TB] FAIL b2b_latency got=%0d expected=384", de); end
        for (int k = 0; k < 16; k++) begin
            got = {mem_a[64 + 4 * k], mem_a[65 + 4 * k], mem_a[66 + 4 * k], mem_a[67 + 4 * k]};
            checks++;
            if (got !== exp_p[k]) begin
                failures++; $display("[TB] FAIL b2b_pair%0d got=%h expected=%h", k, got, exp_p[k]);
            end
        end
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        tb_we_a = 1'b0;
        tb_we_b = 1'b0;
        tb_addr = 8'h00;
        tb_data = 8'h00;
        test_reset();
        test_single_pair();
        test_full_run();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        checks += 2;
        if (viol_a != 0) begin failures++; $display("[TB] FAIL wr_range_a got=%0d expected=0", viol_a); end
        if (viol_b != 0) begin failures++; $display("[TB] FAIL wr_range_b got=%0d expected=0", viol_b); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
